// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants used by the write-back, ID/EX and forwarding blocks.
package cpu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_ZERO   = 0;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
endpackage

// File: rtl/regfile_core.sv
// Architectural register array: synchronous write with clear, two combinational
// read ports with register-0 hardwiring and same-cycle write-through bypass.
module regfile_core #(
  parameter int DW = cpu_pkg::DATA_WIDTH,
  parameter int AW = cpu_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);
  import cpu_pkg::*;

  localparam int NREGS = 2 ** AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          wr_ok;

  // Guard register 0 here as well so the core is safe on its own.
  assign wr_ok = we && (waddr != ZERO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
    end else if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    if (raddr1 == ZERO_ADDR)                 rdata1 = '0;
    else if (wr_ok && (raddr1 == waddr))     rdata1 = wdata;
    else                                     rdata1 = regs_q[raddr1];
  end

  always_comb begin
    if (raddr2 == ZERO_ADDR)                 rdata2 = '0;
    else if (wr_ok && (raddr2 == waddr))     rdata2 = wdata;
    else                                     rdata2 = regs_q[raddr2];
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects memory or ALU data, qualifies the write and commits it
// to the register file, counting every committed write.
module wb_regfile #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] DM_data,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [ADDR_WIDTH-1:0] Write_Address,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Read_Address1,
  input  logic [ADDR_WIDTH-1:0] Read_Address2,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  output logic [DATA_WIDTH-1:0] Write_data,
  output logic [CNT_WIDTH-1:0]  commit_count
);
  import cpu_pkg::*;

  logic                 we;
  logic [CNT_WIDTH-1:0] commit_count_q;
  logic [CNT_WIDTH-1:0] commit_count_d;

  always_comb begin
    Write_data = MemtoReg ? DM_data : ALU_result;
  end

  // Reset both drops the write and disables bypass, since bypass keys off we.
  assign we = RegWrite && !rst && (Write_Address != ADDR_WIDTH'(REG_ZERO));

  always_comb begin
    commit_count_d = commit_count_q;
    if (rst)     commit_count_d = '0;
    else if (we) commit_count_d = commit_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    commit_count_q <= commit_count_d;
  end

  assign commit_count = commit_count_q;

  regfile_core #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (Write_Address),
    .wdata  (Write_data),
    .raddr1 (Read_Address1),
    .raddr2 (Read_Address2),
    .rdata1 (Read_data1),
    .rdata2 (Read_data2)
  );
endmodule
